// File: rtl/mem_access_stage.sv
// MEM stage: classifies ops, runs req/ack data-bus loads/stores, aligns/extends loads, registers MEM/WB.
// Latency 1 cycle for pass-through/illegal, >=2 for bus ops; stalls upstream until ack or timeout.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int REG_ADDR_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [3:0]            mem_read,
   input  logic [3:0]            mem_write,
   input  logic                  mem_sign_extend,
   input  logic [1:0]            mem_to_reg,
   input  logic                  reg_write,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [31:0]           alu_result,
   input  logic [31:0]           store_data,
   input  logic [31:0]           pc_plus4,
   output logic                  stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [31:0]           dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [31:0]           wb_data,
   output logic                  mem_err
);
   typedef enum logic {IDLE, BUS} state_t;
   localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t                state, state_nxt;
   logic [7:0]            tmo_cnt;
   logic [1:0]            off_q;
   logic [3:0]            size_q;
   logic                  sign_q;
   logic                  rw_q;
   logic [REG_ADDR_W-1:0] rd_q;

   logic [3:0]  size;
   logic        is_mem;
   logic        illegal;
   logic        accept;
   logic [31:0] lanes;
   logic [31:0] load_val;
   logic [31:0] pass_val;

   assign size   = mem_read | mem_write;
   assign is_mem = |size;
   assign accept = (state == IDLE) && in_valid && is_mem && !illegal;

   always_comb begin
      illegal = (|mem_read) && (|mem_write);
      case (size)
         4'b0001: begin end
         4'b0011: if (alu_result[0]) illegal = 1'b1;
         4'b1111: if (|alu_result[1:0]) illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (mem_to_reg)
         2'b01:   pass_val = alu_result;
         2'b10:   pass_val = pc_plus4;
         default: pass_val = 32'h0;
      endcase
   end

   // Shift the addressed lanes down to bit 0, then extend from the access width.
   assign lanes = dmem_rdata >> {off_q, 3'b000};
   always_comb begin
      case (size_q)
         4'b0001: load_val = {{24{sign_q & lanes[7]}}, lanes[7:0]};
         4'b0011: load_val = {{16{sign_q & lanes[15]}}, lanes[15:0]};
         default: load_val = lanes;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Reset gates the Mealy stall so a held upstream mem op cannot keep it asserted.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUS;
               stall     = rst_n;
            end
         end
         BUS: begin
            stall = 1'b1;
            if (dmem_ack || tmo_cnt == TERM_CNT) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= 32'h0;
         dmem_be      <= 4'h0;
         dmem_wdata   <= 32'h0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= 32'h0;
         mem_err      <= 1'b0;
         tmo_cnt      <= 8'h0;
         off_q        <= 2'b00;
         size_q       <= 4'h0;
         sign_q       <= 1'b0;
         rw_q         <= 1'b0;
         rd_q         <= '0;
      end else begin
         wb_valid <= 1'b0;
         mem_err  <= 1'b0;
         if (state == IDLE) begin
            if (in_valid && !is_mem) begin
               wb_valid     <= 1'b1;
               wb_reg_write <= reg_write;
               wb_rd        <= rd;
               wb_data      <= pass_val;
            end else if (in_valid && illegal) begin
               wb_valid     <= 1'b1;
               wb_reg_write <= 1'b0;
               wb_rd        <= rd;
               wb_data      <= 32'h0;
               mem_err      <= 1'b1;
            end else if (accept) begin
               dmem_req   <= 1'b1;
               dmem_we    <= |mem_write;
               dmem_addr  <= {alu_result[31:2], 2'b00};
               dmem_be    <= size << alu_result[1:0];
               dmem_wdata <= store_data << {alu_result[1:0], 3'b000};
               tmo_cnt    <= 8'h0;
               off_q      <= alu_result[1:0];
               size_q     <= size;
               sign_q     <= mem_sign_extend;
               rw_q       <= reg_write;
               rd_q       <= rd;
            end
         end else if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= rw_q & ~dmem_we;
            wb_rd        <= rd_q;
            wb_data      <= dmem_we ? 32'h0 : load_val;
         end else if (tmo_cnt == TERM_CNT) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= rd_q;
            wb_data      <= 32'h0;
            mem_err      <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: byte-level reference memory plus a req/ack bus responder.
module tb_mem_access_stage;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  mem_read, mem_write;
   logic        mem_sign_extend;
   logic [1:0]  mem_to_reg;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] alu_result, store_data, pc_plus4;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic        wb_valid, wb_reg_write, mem_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ref_mem [0:1023];
   logic [31:0] bus_mem [0:255];

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_sign_extend(mem_sign_extend), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd),
      .alu_result(alu_result), .store_data(store_data), .pc_plus4(pc_plus4), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_word(input int widx, input logic [31:0] v);
      bus_mem[widx] = v;
      for (int b = 0; b < 4; b++) ref_mem[widx*4 + b] = v[8*b +: 8];
   endtask

   task automatic do_op(input logic [3:0] mr, input logic [3:0] mw, input logic sx,
                        input logic [1:0] m2r, input logic rw, input logic [4:0] rdi,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                        input int ackat);
      int nb, off, base, c;
      logic is_mem, bad, ok, is_st, success, hold;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_ld, pass, w;
      bit done;
      nb     = ((mr | mw) == 4'b0001) ? 1 : ((mr | mw) == 4'b0011) ? 2 : ((mr | mw) == 4'b1111) ? 4 : 0;
      off    = int'(alu[1:0]);
      base   = int'(alu[9:0]);
      is_mem = (mr | mw) != 4'h0;
      bad    = is_mem && ((mr != 4'h0 && mw != 4'h0) || nb == 0 || (off % nb) != 0);
      ok     = is_mem && !bad;
      is_st  = mw != 4'h0;
      success = ackat >= 1 && ackat <= TO;
      exp_be = 4'h0;
      exp_ld = 32'h0;
      for (int i = 0; i < nb; i++) begin
         if (off + i < 4) exp_be[off + i] = 1'b1;
         if (ok) exp_ld = exp_ld | (32'(ref_mem[base + i]) << (8*i));
      end
      if (ok && sx && nb < 4 && exp_ld[8*nb-1]) exp_ld = exp_ld | (32'hFFFF_FFFF << (8*nb));
      exp_wd = sd << (8*off);
      pass   = (m2r == 2'b01) ? alu : (m2r == 2'b10) ? pc : 32'h0;

      @(negedge clk);
      in_valid = 1'b1; mem_read = mr; mem_write = mw; mem_sign_extend = sx; mem_to_reg = m2r;
      reg_write = rw; rd = rdi; alu_result = alu; store_data = sd; pc_plus4 = pc;
      #1 check("stall_accept", stall, ok);
      @(posedge clk);
      if (ok) begin
         c = 1; done = 0;
         while (!done) begin
            @(negedge clk);
            check("bus_req", dmem_req, 1);
            check("bus_we", dmem_we, is_st);
            check("bus_addr", dmem_addr, {alu[31:2], 2'b00});
            check("bus_be", dmem_be, exp_be);
            if (is_st) check("bus_wdata", dmem_wdata, exp_wd);
            check("stall_bus", stall, 1);
            check("wb_valid_bus", wb_valid, 0);
            dmem_rdata = $urandom;
            if (c == ackat) begin
               dmem_ack = 1'b1;
               dmem_rdata = bus_mem[alu[9:2]];
               if (dmem_we) begin
                  w = bus_mem[dmem_addr[9:2]];
                  for (int b = 0; b < 4; b++) if (dmem_be[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
                  bus_mem[dmem_addr[9:2]] = w;
               end
               done = 1;
            end else if (c == TO) begin
               done = 1;
            end
            @(posedge clk);
            #1 dmem_ack = 1'b0;
            c++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("wb_valid", wb_valid, 1);
      check("mem_err", mem_err, bad || (ok && !success));
      check("wb_reg_write", wb_reg_write, !is_mem ? rw : (ok && success && !is_st) ? rw : 1'b0);
      check("req_done", dmem_req, 0);
      check("stall_done", stall, 0);
      hold = 0;
      if (!is_mem) begin
         check("wb_rd", wb_rd, rdi);
         check("wb_data_pass", wb_data, pass);
         hold = 1;
      end else if (ok && success && !is_st) begin
         check("wb_rd", wb_rd, rdi);
         check("wb_data_load", wb_data, exp_ld);
         hold = 1;
      end
      if (ok && success && is_st)
         for (int i = 0; i < nb; i++) ref_mem[base + i] = sd[8*i +: 8];
      @(negedge clk);
      check("wb_valid_pulse", wb_valid, 0);
      check("mem_err_pulse", mem_err, 0);
      if (hold) begin
         check("wb_rd_hold", wb_rd, rdi);
         check("wb_data_hold", wb_data, !is_mem ? pass : exp_ld);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] sizes [3];
      logic [3:0] sz, mr, mw;
      logic [31:0] a;
      sizes = '{4'b0001, 4'b0011, 4'b1111};
      rst_n = 1'b0; in_valid = 1'b0; mem_read = 4'h0; mem_write = 4'h0; mem_sign_extend = 1'b0;
      mem_to_reg = 2'b00; reg_write = 1'b0; rd = 5'd0; alu_result = 32'h0; store_data = 32'h0;
      pc_plus4 = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
      for (int wi = 0; wi < 256; wi++) set_word(wi, $urandom);
      #12;
      check("rst_req", dmem_req, 0);
      check("rst_stall", stall, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_mem_err", mem_err, 0);
      check("rst_be", dmem_be, 0);
      @(negedge clk) rst_n = 1'b1;

      do_op(4'h0, 4'h0, 1'b0, 2'b01, 1'b1, 5'd3, 32'h0000_1234, 32'h0, 32'h0, 0);
      set_word(32'h100 >> 2, 32'h80AA_BBCC);
      do_op(4'b0001, 4'h0, 1'b1, 2'b00, 1'b1, 5'd4, 32'h0000_0103, 32'h0, 32'h0, 3);
      set_word(32'h200 >> 2, 32'hBEEF_0000);
      do_op(4'b0011, 4'h0, 1'b0, 2'b00, 1'b1, 5'd5, 32'h0000_0202, 32'h0, 32'h0, 1);
      do_op(4'h0, 4'b0001, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0, 2);
      do_op(4'b1111, 4'h0, 1'b0, 2'b00, 1'b1, 5'd6, 32'h0000_0102, 32'h0, 32'h0, 1);
      do_op(4'b1111, 4'h0, 1'b0, 2'b00, 1'b1, 5'd6, 32'h0000_0104, 32'h0, 32'h0, 0);
      do_op(4'b1111, 4'h0, 1'b0, 2'b00, 1'b1, 5'd8, 32'h0000_0100, 32'h0, 32'h0, TO);

      // Reset in the middle of a bus transaction with the upstream op still held.
      @(negedge clk);
      in_valid = 1'b1; mem_read = 4'b1111; mem_write = 4'h0; alu_result = 32'h0000_0100; rd = 5'd9;
      reg_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mid_bus_req", dmem_req, 1);
      rst_n = 1'b0;
      #1;
      check("arst_req", dmem_req, 0);
      check("arst_stall", stall, 0);
      check("arst_wb_valid", wb_valid, 0);
      check("arst_wb_rd", wb_rd, 0);
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      do_op(4'h0, 4'h0, 1'b0, 2'b01, 1'b1, 5'd7, 32'h0000_0005, 32'h0, 32'h0, 0);

      for (int n = 0; n < 250; n++) begin
         sz = sizes[$urandom_range(0, 2)];
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 4'b0011) a[0] = 1'b0;
            else if (sz == 4'b1111) a[1:0] = 2'b00;
         end
         case ($urandom_range(0, 3))
            0:       begin mr = 4'h0; mw = 4'h0; end
            1:       begin mr = sz;   mw = 4'h0; end
            2:       begin mr = 4'h0; mw = sz;   end
            default: begin mr = 4'($urandom); mw = 4'($urandom); end
         endcase
         do_op(mr, mw, 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
               $urandom, $urandom_range(0, TO));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the pipelined 32-bit CPU. Sits directly downstream of the instruction decoder and ALU and consumes the decoder's MemRead/MemWrite byte masks, MemSignExtend and MemToReg selects. Runs load/store transactions on a req/ack data-memory bus, aligns and extends load data, selects the writeback value, and registers the MEM/WB outputs. Stalls the upstream pipeline while a bus transaction is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: max cycles `dmem_req` is held without `dmem_ack` before abort (1..255)
- REG_ADDR_W, 5: destination register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM slot holds a valid instruction
- mem_read  in  4  decoder MemRead mask (0000/0001/0011/1111)
- mem_write  in  4  decoder MemWrite mask (0000/0001/0011/1111)
- mem_sign_extend  in  1  sign-extend byte/half loads
- mem_to_reg  in  2  00 load data, 01 ALU result, 10 pc_plus4, 11 reserved
- reg_write  in  1  instruction writes rd
- rd  in  REG_ADDR_W  destination register
- alu_result  in  32  effective address or ALU value
- store_data  in  32  Rb value for stores
- pc_plus4  in  32  link value for JAL
- stall  out  1  upstream must hold EX/MEM inputs
- dmem_req, dmem_we  out  1 each  bus request / write
- dmem_addr  out  32  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  transaction complete
- wb_valid, wb_reg_write  out  1 each  MEM/WB valid / write enable
- wb_rd  out  REG_ADDR_W  MEM/WB destination
- wb_data  out  32  writeback value
- mem_err  out  1  one-cycle pulse: illegal, misaligned or timed-out access

## Operation
- FSM states IDLE, BUS. Reset: IDLE; every output 0.
- Op class in IDLE with in_valid: mem op if mem_read or mem_write nonzero; else pass-through.
- Pass-through: next edge loads wb_valid=1, wb_reg_write=reg_write, wb_rd=rd, wb_data = alu_result (01), pc_plus4 (10), 0 (00/11). No stall.
- Illegal: both masks nonzero, mask not in {0001,0011,1111}, or misaligned (half with addr[0]=1, word with addr[1:0]≠00). No bus access; next edge wb_valid=1, wb_reg_write=0, mem_err=1.
- Legal mem op: stall=1 combinationally this cycle; edge captures addr, masks, store data, rd, reg_write, sign flag; enter BUS.
- BUS: dmem_req=1 registered; dmem_addr={addr[31:2],2'b00}; dmem_be = mask << addr[1:0]; dmem_we = (mem_write≠0); dmem_wdata = store_data << 8*addr[1:0]. All held stable until ack. stall=1 throughout.
- Ack edge: load: lanes = dmem_rdata >> 8*addr[1:0], masked to width, zero- or sign-extended from bit 7/15; wb_data = that value, wb_reg_write = captured reg_write. Store: wb_reg_write=0. wb_valid=1; req drops; back to IDLE; stall drops the same cycle.
- Timeout counter (8 bit) clears on BUS entry, increments each BUS cycle without ack; at TIMEOUT_CYCLES: req drops, IDLE, wb_valid=1, wb_reg_write=0, mem_err=1. Ack in the same cycle as terminal count counts as success.
- in_valid=0 in IDLE: wb_valid=0 next edge, other wb fields hold.
- rst_n low any time, incl. mid-BUS: req drops immediately, state IDLE, outputs 0; no partial writeback.

## Timing
- Pass-through / illegal latency: 1 cycle to wb_*.
- Mem op: accept cycle 0 (stall=1), req high cycles 1..k, ack sampled at cycle k, wb_* and stall=0 visible cycle k+1. Minimum 2 cycles (ack at cycle 1).
- stall is Mealy in IDLE, registered-state-driven in BUS; bus outputs are pure register outputs.
- wb_valid, mem_err are single-cycle pulses per instruction.
- Back-to-back: a new instruction may be accepted the cycle after returning to IDLE.

## Test plan
- ADD-class pass-through: mem_to_reg=01, alu_result=0x0000_1234, rd=3 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, stall never high.
- LBS at addr 0x103, rdata=0x80AA_BBCC, ack 3 cycles after req -> be=1000, addr=0x100, wb_data=0xFFFF_FF80, stall high exactly 4 cycles.
- LH zero-extend at 0x202, rdata=0xBEEF_0000, ack at cycle 1 -> wb_data=0x0000_BEEF, 2-cycle latency.
- SB at 0x101, store_data=0x0000_00A5 -> dmem_we=1, be=0010, wdata=0x0000_A500, wb_reg_write=0.
- LW at 0x102 -> no req, mem_err pulse, wb_reg_write=0; LW with no ack, TIMEOUT_CYCLES=4 -> req high 4 cycles, then mem_err, stall released.
- rst_n low in BUS cycle 2 -> req, stall, wb_* go 0 asynchronously; after release, next ADDI executes normally.
